tholin_io_frontend: RTL and testbench
=====================================

// Module: tholin_io_frontend
// PURPOSE
//  Input conditioning stage between the user-area pads and wrapped_tholin_riscv.
//  - Synchronises the raw pad reset (io_in[0]) and the 33 pad inputs (io_in[37:5]) into wb_clk_i.
//  - Optionally glitch-filters the pad inputs.
//  - Sequences a stretched core reset.
//  - Latches the LA custom_settings bits when the core leaves reset.
// PARAMETERS
//  NPINS        33  conditioned pad inputs (io_in[37:5])
//  NSET         2   custom_settings width (la_data_in[1:0])
//  SYNC_STAGES  2   synchroniser depth; minimum 2
//  FILT_CYCLES  4   consecutive cycles a changed input must be stable before it is passed; minimum 2
//  HOLD_CYCLES  16  cycles core reset stays asserted after the synchronised pad reset releases; minimum 1
// PORTS
//  wb_clk_i         in   1      sole clock
//  wb_rst_i         in   1      asynchronous, active-high reset
//  pad_rst_n_i      in   1      raw io_in[0], active-low core reset request
//  pad_in_i         in   NPINS  raw io_in[37:5]
//  filt_en_i        in   1      raw la_data_in[2]; 1 = glitch filter on
//  settings_i       in   NSET   la_data_in[1:0]
//  core_rst_n_o     out  1      registered rst_n to the core
//  core_io_in_o     out  NPINS  registered, conditioned io_in to the core
//  core_settings_o  out  NSET   custom_settings to the core, latched at reset release
//  state_o          out  2      sequencer state (debug/LA readback)
// BEHAVIOUR
//  Reset (wb_rst_i=1, async):
//  - All flops clear: sync chains 0, filter counters 0.
//  - core_io_in_o=0, core_rst_n_o=0, core_settings_o=0, state=IDLE.
//  - wb_rst_i overrides every other event.
//  Synchronisers:
//  - SYNC_STAGES-flop chains on pad_rst_n_i, each pad_in_i bit and filt_en_i; the "_s" suffix below means the synchronised value.
//  Filter, per pin, counter width $clog2(FILT_CYCLES):
//  - filt_en_s=0: counter held at 0; core_io_in_o[i] <= in_s[i] every cycle.
//    Pad-to-output latency is SYNC_STAGES+1 edges.
//  - filt_en_s=1, in_s[i]==out[i]: counter cleared.
//  - filt_en_s=1, in_s[i]!=out[i], counter<FILT_CYCLES-1: counter increments.
//  - filt_en_s=1, in_s[i]!=out[i], counter==FILT_CYCLES-1: out[i]<=in_s[i]; counter cleared.
//    Pad-to-output latency is SYNC_STAGES+FILT_CYCLES edges.
//    A pulse shorter than FILT_CYCLES synchronised cycles never reaches the output.
//  - filt_en_s toggling mid-count: counters clear; no partial count carries over.
//  Reset sequencer (2-bit state; core_rst_n_o is a flop, 1 only in RUN):
//  - IDLE (0): rst_s=1 -> HOLD with hold_cnt=0.
//  - HOLD (1): rst_s=0 -> IDLE, count discarded.
//              rst_s=1, hold_cnt==HOLD_CYCLES-1 -> RUN; core_rst_n_o<=1; core_settings_o<=settings_i.
//              rst_s=1 otherwise -> hold_cnt+1.
//  - RUN (2): rst_s=0 -> IDLE; core_rst_n_o<=0.
//  - Encoding 3 is illegal; it recovers to IDLE with core_rst_n_o=0.
//  - core_settings_o changes only on the HOLD->RUN edge; settings_i changes while in RUN are ignored.
//  - Release latency: core_rst_n_o rises on the (SYNC_STAGES+HOLD_CYCLES+1)th edge after pad_rst_n_i rises.
//  - Assert latency: core_rst_n_o falls on the (SYNC_STAGES+1)th edge after pad_rst_n_i falls.
//  - hold_cnt width is $clog2(HOLD_CYCLES+1) and never wraps.
//  - core_io_in_o stays live in every state; the core ignores it while in reset.
// STRUCTURE
//  - Package tholin_io_pkg: state enum (IDLE/HOLD/RUN) and the default NPINS/NSET/timing localparams, shared with the wrapper.
//  - Sub-module tholin_pin_filter: one pin's sync chain, filter counter and output flop; instantiated NPINS times in a generate loop.
//  - Sequencer and settings latch live in the top.
// TESTING (defaults; edge 1 = first wb_clk_i rise after the stimulus)
//  1. Assert wb_rst_i mid-RUN with filter on and a count in flight
//     -> all outputs 0 and state_o=0 immediately; after release, the normal sequence restarts.
//  2. filt_en=0, pad_in_i[0] 0->1
//     -> core_io_in_o[0]=1 after edge 3.
//  3. filt_en=1; 3-cycle high pulse on pad_in_i[5] -> output stays 0.
//     6-cycle high level -> output rises after edge 6.
//  4. settings_i=2'b10; pad_rst_n_i 0->1
//     -> core_rst_n_o=1 and core_settings_o=2'b10 after edge 19, state_o=2.
//     Then settings_i=2'b01 in RUN -> core_settings_o holds 2'b10.
//  5. pad_rst_n_i glitches low for 2 cycles during HOLD
//     -> state returns to IDLE; core_rst_n_o rises only 19 edges after the final rise.
//     pad_rst_n_i low in RUN -> core_rst_n_o=0 after edge 3.

Source files
------------

// File: rtl/tholin_io_pkg.sv
// Shared types and default sizing for the tholin pad-input frontend and its wrapper.
package tholin_io_pkg;

  localparam int NPINS_DEF       = 33;
  localparam int NSET_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 4;
  localparam int HOLD_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/tholin_io_frontend_if.sv
// Pad-side inputs and core-side conditioned outputs of the tholin frontend.
interface tholin_io_frontend_if #(
  parameter int NPINS = tholin_io_pkg::NPINS_DEF,
  parameter int NSET  = tholin_io_pkg::NSET_DEF
);

  logic             pad_rst_n_i;
  logic [NPINS-1:0] pad_in_i;
  logic             filt_en_i;
  logic [NSET-1:0]  settings_i;
  logic             core_rst_n_o;
  logic [NPINS-1:0] core_io_in_o;
  logic [NSET-1:0]  core_settings_o;
  logic [1:0]       state_o;

  modport master (
    output pad_rst_n_i, pad_in_i, filt_en_i, settings_i,
    input  core_rst_n_o, core_io_in_o, core_settings_o, state_o
  );

  modport slave (
    input  pad_rst_n_i, pad_in_i, filt_en_i, settings_i,
    output core_rst_n_o, core_io_in_o, core_settings_o, state_o
  );

endinterface

// File: rtl/tholin_io_frontend_pin_filter.sv
// One pad input: synchroniser chain followed by an optional stability filter and output flop.
module tholin_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic filt_en,
  output logic pin_q
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   in_s;
  logic [CW-1:0]          cnt;

  assign in_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad};
    end
  end

  // A changed level is only passed once it has differed from the output for FILT_CYCLES edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      pin_q <= 1'b0;
    end else if (!filt_en) begin
      cnt   <= '0;
      pin_q <= in_s;
    end else if (in_s == pin_q) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_CYCLES - 1)) begin
      cnt   <= '0;
      pin_q <= in_s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tholin_io_frontend.sv
// Conditions the user-area pad inputs into wb_clk_i and sequences a stretched core reset.
module tholin_io_frontend
  import tholin_io_pkg::*;
#(
  parameter int NPINS       = NPINS_DEF,
  parameter int NSET        = NSET_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  tholin_io_frontend_if.slave  bus
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] fe_sync;
  logic                   rst_s;
  logic                   filt_en_s;
  logic [NPINS-1:0]       io_q;
  seq_state_t             state;
  logic [HW-1:0]          hold_cnt;
  logic                   core_rst_n;
  logic [NSET-1:0]        settings_q;

  assign rst_s     = rst_sync[SYNC_STAGES-1];
  assign filt_en_s = fe_sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rst_sync <= '0;
      fe_sync  <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], bus.pad_rst_n_i};
      fe_sync  <= {fe_sync[SYNC_STAGES-2:0], bus.filt_en_i};
    end
  end

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    tholin_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_pin (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .pad     (bus.pad_in_i[i]),
      .filt_en (filt_en_s),
      .pin_q   (io_q[i])
    );
  end

  // Any drop of the synchronised reset request restarts the hold period from scratch.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
      settings_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          core_rst_n <= 1'b0;
          if (rst_s) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (!rst_s) begin
            state <= IDLE;
          end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state      <= RUN;
            core_rst_n <= 1'b1;
            settings_q <= bus.settings_i;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!rst_s) begin
            state      <= IDLE;
            core_rst_n <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          core_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_io_in_o    = io_q;
  assign bus.core_rst_n_o    = core_rst_n;
  assign bus.core_settings_o = settings_q;
  assign bus.state_o         = state;

endmodule

// File: tb/tb_tholin_io_frontend.sv
// Randomised and directed bench for tholin_io_frontend against a pad-history reference model.
module tb_tholin_io_frontend;
  import tholin_io_pkg::*;

  localparam int NP   = NPINS_DEF;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  tholin_io_frontend_if #(.NPINS(NP), .NSET(2)) bus ();

  tholin_io_frontend dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: delayed pad history, sliding filter window and a reset-high run length.
  logic [NP-1:0] pad_q[$];
  bit            rst_q[$];
  bit            fe_q[$];
  logic [NP-1:0] win_in[$];
  bit            win_fe[$];
  logic [NP-1:0] exp_io;
  bit            exp_rstn;
  logic [1:0]    exp_state;
  logic [1:0]    exp_set;
  int            run;

  task automatic model_clear();
    pad_q.delete(); rst_q.delete(); fe_q.delete();
    win_in.delete(); win_fe.delete();
    repeat (SYNC) begin
      pad_q.push_back('0); rst_q.push_back(1'b0); fe_q.push_back(1'b0);
    end
    exp_io = '0; exp_rstn = 1'b0; exp_state = 2'd0; exp_set = 2'd0; run = 0;
  endtask

  task automatic tick();
    logic [NP-1:0] cur_pad, in_s, agree;
    logic [1:0]    cur_set;
    bit            cur_rst, cur_fe, rs, fs, all_fe;
    @(posedge clk);
    cur_pad = bus.pad_in_i;
    cur_rst = bus.pad_rst_n_i;
    cur_fe  = bus.filt_en_i;
    cur_set = bus.settings_i;
    #1;
    pad_q.push_back(cur_pad); in_s = pad_q.pop_front();
    rst_q.push_back(cur_rst); rs   = rst_q.pop_front();
    fe_q.push_back(cur_fe);   fs   = fe_q.pop_front();
    win_in.push_back(in_s); win_fe.push_back(fs);
    if (win_in.size() > FILT) begin
      void'(win_in.pop_front()); void'(win_fe.pop_front());
    end
    if (!fs) begin
      exp_io = in_s;
    end else if (win_in.size() == FILT) begin
      all_fe = 1'b1;
      agree  = '1;
      foreach (win_in[j]) begin
        all_fe = all_fe & win_fe[j];
        agree  = agree & (win_in[j] ^ exp_io);
      end
      if (all_fe) exp_io = exp_io ^ agree;
    end
    if (!rs) run = 0;
    else if (run < HOLD + 2) run = run + 1;
    if (run == HOLD + 1) exp_set = cur_set;
    exp_rstn  = (run >= HOLD + 1);
    exp_state = (run == 0) ? 2'd0 : (run <= HOLD) ? 2'd1 : 2'd2;
  endtask

  function automatic logic [NP-1:0] sparse_mask();
    return {($urandom_range(0, 7) == 0), ($urandom() & $urandom() & $urandom())};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.pad_rst_n_i = 1'b0; bus.pad_in_i = '0; bus.filt_en_i = 1'b0; bus.settings_i = 2'b11;
    #2;
    total++; if (bus.core_io_in_o !== '0) $display("[TB] FAIL reset_io: got %h want 0", bus.core_io_in_o); else passed++;
    total++; if (bus.core_rst_n_o !== 1'b0) $display("[TB] FAIL reset_rstn: got %b want 0", bus.core_rst_n_o); else passed++;
    total++; if (bus.core_settings_o !== 2'b00) $display("[TB] FAIL reset_settings: got %b want 00", bus.core_settings_o); else passed++;
    total++; if (bus.state_o !== 2'd0) $display("[TB] FAIL reset_state: got %0d want 0", bus.state_o); else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_passthrough();
    bus.pad_in_i = 33'd1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (bus.core_io_in_o[0] !== (e == 3)) $display("[TB] FAIL pass_latency edge %0d: got %b want %b", e, bus.core_io_in_o[0], (e == 3));
      else passed++;
    end
    for (int c = 0; c < 40; c++) begin
      bus.pad_in_i = {$urandom_range(0, 1) == 1, $urandom()};
      tick();
      total++;
      if (bus.core_io_in_o !== exp_io) $display("[TB] FAIL pass_random cycle %0d: got %h want %h", c, bus.core_io_in_o, exp_io);
      else passed++;
    end
  endtask

  task automatic test_filter();
    bus.pad_in_i = '0; bus.filt_en_i = 1'b0;
    repeat (4) tick();
    bus.filt_en_i = 1'b1;
    repeat (4) tick();
    bus.pad_in_i[5] = 1'b1;
    repeat (3) tick();
    bus.pad_in_i[5] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (bus.core_io_in_o[5] !== 1'b0) $display("[TB] FAIL filt_short_pulse cycle %0d: got %b want 0", c, bus.core_io_in_o[5]);
      else passed++;
    end
    bus.pad_in_i[5] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (bus.core_io_in_o[5] !== (e == 6)) $display("[TB] FAIL filt_level edge %0d: got %b want %b", e, bus.core_io_in_o[5], (e == 6));
      else passed++;
    end
    for (int c = 0; c < 80; c++) begin
      bus.pad_in_i = bus.pad_in_i ^ sparse_mask();
      if ($urandom_range(0, 24) == 0) bus.filt_en_i = ~bus.filt_en_i;
      tick();
      total++;
      if (bus.core_io_in_o !== exp_io) $display("[TB] FAIL filt_random cycle %0d: got %h want %h", c, bus.core_io_in_o, exp_io);
      else passed++;
    end
  endtask

  task automatic test_settings();
    bus.settings_i = 2'b10; bus.pad_rst_n_i = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      total++;
      if (bus.core_rst_n_o !== (e == 19)) $display("[TB] FAIL release_latency edge %0d: got %b want %b", e, bus.core_rst_n_o, (e == 19));
      else passed++;
      if (e == 2 || e == 3) begin
        total++;
        if (bus.state_o !== ((e == 3) ? 2'd1 : 2'd0)) $display("[TB] FAIL enter_hold edge %0d: got %0d want %0d", e, bus.state_o, (e == 3));
        else passed++;
      end
    end
    total++; if (bus.state_o !== 2'd2) $display("[TB] FAIL run_state: got %0d want 2", bus.state_o); else passed++;
    total++; if (bus.core_settings_o !== 2'b10) $display("[TB] FAIL settings_latch: got %b want 10", bus.core_settings_o); else passed++;
    bus.settings_i = 2'b01;
    repeat (5) tick();
    total++; if (bus.core_settings_o !== 2'b10) $display("[TB] FAIL settings_hold: got %b want 10", bus.core_settings_o); else passed++;
    total++; if (bus.core_rst_n_o !== 1'b1) $display("[TB] FAIL run_stays: got %b want 1", bus.core_rst_n_o); else passed++;
  endtask

  task automatic test_glitch();
    bus.pad_rst_n_i = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (bus.core_rst_n_o !== (e < 3)) $display("[TB] FAIL assert_latency edge %0d: got %b want %b", e, bus.core_rst_n_o, (e < 3));
      else passed++;
    end
    bus.pad_rst_n_i = 1'b1;
    repeat (6) tick();
    total++; if (bus.state_o !== 2'd1) $display("[TB] FAIL glitch_in_hold: got %0d want 1", bus.state_o); else passed++;
    bus.pad_rst_n_i = 1'b0;
    repeat (2) tick();
    bus.pad_rst_n_i = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      total++;
      if (bus.core_rst_n_o !== (e == 19)) $display("[TB] FAIL glitch_release edge %0d: got %b want %b", e, bus.core_rst_n_o, (e == 19));
      else passed++;
      if (e == 1) begin
        total++;
        if (bus.state_o !== 2'd0) $display("[TB] FAIL glitch_to_idle: got %0d want 0", bus.state_o);
        else passed++;
      end
    end
  endtask

  task automatic test_random_seq();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) bus.pad_rst_n_i = ~bus.pad_rst_n_i;
      if ($urandom_range(0, 49) == 0) bus.filt_en_i = ~bus.filt_en_i;
      bus.pad_in_i   = bus.pad_in_i ^ sparse_mask();
      bus.settings_i = 2'($urandom_range(0, 3));
      tick();
      total++;
      if (bus.core_io_in_o !== exp_io) $display("[TB] FAIL rand_io cycle %0d: got %h want %h", c, bus.core_io_in_o, exp_io);
      else passed++;
      total++;
      if (bus.core_rst_n_o !== exp_rstn || bus.state_o !== exp_state || bus.core_settings_o !== exp_set)
        $display("[TB] FAIL rand_seq cycle %0d: got rstn=%b st=%0d set=%b want rstn=%b st=%0d set=%b",
                 c, bus.core_rst_n_o, bus.state_o, bus.core_settings_o, exp_rstn, exp_state, exp_set);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_run();
    bus.pad_rst_n_i = 1'b1; bus.filt_en_i = 1'b1; bus.settings_i = 2'b11;
    repeat (25) tick();
    total++; if (bus.state_o !== 2'd2) $display("[TB] FAIL pre_reset_run: got %0d want 2", bus.state_o); else passed++;
    bus.pad_in_i[3] = ~bus.pad_in_i[3];
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.core_io_in_o !== '0 || bus.core_rst_n_o !== 1'b0 || bus.core_settings_o !== 2'b00 || bus.state_o !== 2'd0)
      $display("[TB] FAIL async_reset: got io=%h rstn=%b set=%b st=%0d want all 0",
               bus.core_io_in_o, bus.core_rst_n_o, bus.core_settings_o, bus.state_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int e = 1; e <= 19; e++) begin
      tick();
      total++;
      if (bus.core_rst_n_o !== (e == 19)) $display("[TB] FAIL restart_release edge %0d: got %b want %b", e, bus.core_rst_n_o, (e == 19));
      else passed++;
      total++;
      if (bus.core_io_in_o !== exp_io) $display("[TB] FAIL restart_io edge %0d: got %h want %h", e, bus.core_io_in_o, exp_io);
      else passed++;
    end
    total++; if (bus.core_settings_o !== 2'b11) $display("[TB] FAIL restart_settings: got %b want 11", bus.core_settings_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_filter();
    test_settings();
    test_glitch();
    test_random_seq();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
